// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a shared 4-bit ALU: arbitrate, latch the winner's op,
// execute for one cycle and hold the registered result until the winner takes it.
module alu_req_arbiter #(
    parameter int ARB_MODE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req0_op,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req1_op,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             busy,
    output logic             last_gnt,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state, state_nxt;
    logic       gnt_any, gnt_sel, accept, rsp_take;
    logic       gnt_idx;
    logic [2:0] op_p0;
    logic [3:0] a_p0, b_p0;
    logic [6:0] alu_p0;

    // Packed as {result[3:0], carry, zero, ovf}.
    function automatic logic [6:0] alu_eval(input logic [2:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
        logic [3:0] bx;
        logic [4:0] sum;
        logic [3:0] res;
        logic       c, z, v;
        bx  = (op == 3'd1) ? ~b : b;
        sum = {1'b0, a} + {1'b0, bx} + {4'd0, (op == 3'd1)};
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                res = sum[3:0];
                c   = sum[4];
                v   = (a[3] == bx[3]) && (sum[3] != a[3]);
            end
            3'd2:    res = ~a;
            3'd3:    res = a & b;
            3'd4:    res = a | b;
            3'd5:    res = a ^ b;
            3'd6:    res = {3'b000, ($signed(a) < $signed(b))};
            default: res = {3'b000, (a == b)};
        endcase
        z = (op >= 3'd6) ? ~res[0] : (res == 4'd0);
        return {res, c, z, v};
    endfunction

    always_comb begin
        gnt_any = |req_valid;
        case (req_valid)
            2'b10:   gnt_sel = 1'b1;
            2'b11:   gnt_sel = (ARB_MODE != 0) ? ~last_gnt : 1'b0;
            default: gnt_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        accept    = 1'b0;
        rsp_take  = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any && !rst) begin
                    req_ready[gnt_sel] = 1'b1;
                    accept             = 1'b1;
                    state_nxt          = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[gnt_idx] = 1'b1;
                if (rsp_ready[gnt_idx]) begin
                    rsp_take  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state != IDLE);
    assign alu_p0 = alu_eval(op_p0, a_p0, b_p0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt_idx    <= 1'b0;
            last_gnt   <= 1'b1;
            ops_done   <= '0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                gnt_idx  <= gnt_sel;
                last_gnt <= gnt_sel;
            end
            // EXEC -> RESP boundary: ALU output registered into the response holding regs
            if (state == EXEC)
                {rsp_result, rsp_carry, rsp_zero, rsp_ovf} <= alu_p0;
            if (rsp_take)
                ops_done <= ops_done + CNT_W'(1);
        end
    end

    // IDLE -> EXEC boundary: operand capture is data-only, no reset needed
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= gnt_sel ? req1_op : req0_op;
            a_p0  <= gnt_sel ? req1_a  : req0_a;
            b_p0  <= gnt_sel ? req1_b  : req0_b;
        end
    end

endmodule
